// File: rtl/ahb_err_resp_slave.sv
// AHB default slave: answers unmapped transfers with a two-cycle ERROR (or zero-wait OKAY).
// Optional statistics (counter, last address capture, strobe) enabled by `AHB_ERR_SLV_STATS_EN.
module ahb_err_resp_slave #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int CNT_W    = 16,
   parameter int ERR_MODE = 1
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL_DEFAULT,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic [1:0]        HRESP,
   output logic [DATA_W-1:0] HRDATA,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] last_err_addr,
   output logic              last_err_write,
   output logic              err_pulse
);

   localparam bit         ERR_EN    = (ERR_MODE != 0);
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic       hreadyout_nxt;
   logic [1:0] hresp_nxt;
   logic       valid;

   // NONSEQ/SEQ only; IDLE and BUSY never produce an error or touch the statistics
   assign valid  = HSEL_DEFAULT & HREADY & HTRANS[1];
   assign HRDATA = '0;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (valid && ERR_EN) state_nxt = ST_ERR1;
         // HREADY is low on the bus during the wait state, so nothing is sampled here
         ST_ERR1: state_nxt = ST_ERR2;
         ST_ERR2: state_nxt = (valid && ERR_EN) ? ST_ERR1 : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      hreadyout_nxt = (state_nxt != ST_ERR1);
      hresp_nxt     = (state_nxt == ST_IDLE) ? RESP_OKAY : RESP_ERR;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= RESP_OKAY;
      end else begin
         state     <= state_nxt;
         HREADYOUT <= hreadyout_nxt;
         HRESP     <= hresp_nxt;
      end
   end

`ifdef AHB_ERR_SLV_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic              pulse_q;

   // A transfer coinciding with clr_stats wins: it restarts the count at one
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= valid;
         if (valid) begin
            if (clr_stats)       cnt_q <= CNT_ONE;
            else if (~&cnt_q)    cnt_q <= cnt_q + CNT_ONE;
            addr_q  <= HADDR;
            write_q <= HWRITE;
         end else if (clr_stats) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
         end
      end
   end

   assign err_count      = cnt_q;
   assign last_err_addr  = addr_q;
   assign last_err_write = write_q;
   assign err_pulse      = pulse_q;
`else
   logic unused_stats_in;
   assign unused_stats_in = ^{clr_stats, HADDR, HWRITE};

   assign err_count      = '0;
   assign last_err_addr  = '0;
   assign last_err_write = 1'b0;
   assign err_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_err_resp_slave.sv
// Bench for ahb_err_resp_slave: an ERROR-mode instance (CNT_W=4) and an OKAY-mode instance
// share the bus; a cycle-indexed response timeline model is checked every cycle.
module tb_ahb_err_resp_slave;

`ifdef AHB_ERR_SLV_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = T_IDLE;
   logic        hwrite = 1'b0;
   logic        clr = 1'b0;
   logic        hready;

   logic        e_ready, e_wr, e_pulse;
   logic [1:0]  e_resp;
   logic [31:0] e_rdata, e_addr;
   logic [3:0]  e_cnt;
   logic        o_ready, o_wr, o_pulse;
   logic [1:0]  o_resp;
   logic [31:0] o_rdata, o_addr;
   logic [15:0] o_cnt;

   ahb_err_resp_slave #(.ADDR_W(32), .DATA_W(32), .CNT_W(4), .ERR_MODE(1)) u_err (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_DEFAULT(hsel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HREADY(hready), .HREADYOUT(e_ready), .HRESP(e_resp), .HRDATA(e_rdata),
      .clr_stats(clr), .err_count(e_cnt), .last_err_addr(e_addr), .last_err_write(e_wr),
      .err_pulse(e_pulse));

   ahb_err_resp_slave #(.ADDR_W(32), .DATA_W(32), .CNT_W(16), .ERR_MODE(0)) u_okay (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_DEFAULT(hsel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HREADY(hready), .HREADYOUT(o_ready), .HRESP(o_resp), .HRDATA(o_rdata),
      .clr_stats(clr), .err_count(o_cnt), .last_err_addr(o_addr), .last_err_write(o_wr),
      .err_pulse(o_pulse));

   // Model: sched[c] is the ERROR-mode data-phase response in cycle c (0 OKAY, 1 wait, 2 final)
   logic [1:0]  sched [0:1023] = '{default: 2'd0};
   int          cyc = 0;
   int          m_cnt_e = 0, m_cnt_o = 0;
   logic [31:0] m_addr = '0;
   logic        m_wr = 1'b0, m_pulse = 1'b0;
   logic        valid_now;

   // The bus ready follows the model's expected response, not the DUT's
   assign hready    = (sched[cyc] != 2'd1);
   assign valid_now = hsel && hready && htrans[1];

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sched[cyc] <= 2'd0; sched[cyc+1] <= 2'd0; sched[cyc+2] <= 2'd0;
         m_cnt_e <= 0; m_cnt_o <= 0; m_addr <= '0; m_wr <= 1'b0; m_pulse <= 1'b0;
      end else begin
         if (valid_now) begin
            sched[cyc+1] <= 2'd1;
            sched[cyc+2] <= 2'd2;
            m_cnt_e <= clr ? 1 : ((m_cnt_e == 15) ? 15 : m_cnt_e + 1);
            m_cnt_o <= clr ? 1 : ((m_cnt_o == 65535) ? 65535 : m_cnt_o + 1);
            m_addr  <= haddr;
            m_wr    <= hwrite;
         end else if (clr) begin
            m_cnt_e <= 0; m_cnt_o <= 0; m_addr <= '0; m_wr <= 1'b0;
         end
         m_pulse <= valid_now;
         cyc     <= cyc + 1;
      end
   end

   int n_chk = 0, n_err = 0;
   bit started = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sx(input logic [63:0] v);
      return STATS ? v : 64'd0;
   endfunction

   // Per-cycle comparison against the model
   always @(negedge HCLK) begin
      if (started) begin
         chk("e_ready", 64'(e_ready), 64'(sched[cyc] != 2'd1));
         chk("e_resp",  64'(e_resp),  (sched[cyc] != 2'd0) ? 64'd1 : 64'd0);
         chk("e_rdata", 64'(e_rdata), 64'd0);
         chk("o_ready", 64'(o_ready), 64'd1);
         chk("o_resp",  64'(o_resp),  64'd0);
         chk("o_rdata", 64'(o_rdata), 64'd0);
         chk("e_cnt",   64'(e_cnt),   sx(64'(m_cnt_e)));
         chk("o_cnt",   64'(o_cnt),   sx(64'(m_cnt_o)));
         chk("e_addr",  64'(e_addr),  sx(64'(m_addr)));
         chk("o_addr",  64'(o_addr),  sx(64'(m_addr)));
         chk("e_wr",    64'(e_wr),    sx(64'(m_wr)));
         chk("e_pulse", 64'(e_pulse), sx(64'(m_pulse)));
         chk("o_pulse", 64'(o_pulse), sx(64'(m_pulse)));
      end
   end

   task automatic step(input logic s, input logic [1:0] t, input logic [31:0] a,
                       input logic w, input logic c);
      hsel = s; htrans = t; haddr = a; hwrite = w; clr = c;
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_step();
      step(1'b1, T_IDLE, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      hsel = 1'b0; htrans = T_IDLE; clr = 1'b0;
      HRESETn = 1'b0;
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
   endtask

   initial begin
      HRESETn = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      started = 1'b1;
      chk("rst_ready", 64'(e_ready), 64'd1);
      chk("rst_resp",  64'(e_resp),  64'd0);
      chk("rst_rdata", 64'(e_rdata), 64'd0);
      chk("rst_cnt",   64'(e_cnt),   64'd0);
      HRESETn = 1'b1;
      repeat (5) idle_step();
      chk("idle_cnt", 64'(e_cnt), 64'd0);
      chk("idle_resp", 64'(e_resp), 64'd0);

      // single error write
      step(1'b1, T_NONSEQ, 32'hDEAD_0000, 1'b1, 1'b0);
      chk("single_err1_ready", 64'(e_ready), 64'd0);
      chk("single_err1_resp",  64'(e_resp),  64'd1);
      chk("single_pulse",      64'(e_pulse), sx(64'd1));
      step(1'b0, T_IDLE, 32'h0, 1'b0, 1'b0);
      chk("single_err2_ready", 64'(e_ready), 64'd1);
      chk("single_err2_resp",  64'(e_resp),  64'd1);
      chk("single_pulse_off",  64'(e_pulse), 64'd0);
      idle_step();
      chk("single_okay_resp", 64'(e_resp), 64'd0);
      chk("single_cnt",  64'(e_cnt),  sx(64'd1));
      chk("single_addr", 64'(e_addr), sx(64'hDEAD_0000));
      chk("single_wr",   64'(e_wr),   sx(64'd1));

      // back-to-back: SEQ held through ERR1, sampled in ERR2
      do_reset();
      step(1'b1, T_NONSEQ, 32'h100, 1'b0, 1'b0);
      chk("b2b_err1a", 64'(e_ready), 64'd0);
      step(1'b1, T_SEQ, 32'h104, 1'b0, 1'b0);
      chk("b2b_err2a_ready", 64'(e_ready), 64'd1);
      chk("b2b_err2a_resp",  64'(e_resp),  64'd1);
      step(1'b1, T_SEQ, 32'h104, 1'b0, 1'b0);
      chk("b2b_err1b", 64'(e_ready), 64'd0);
      idle_step();
      chk("b2b_err2b", 64'(e_resp), 64'd1);
      idle_step();
      chk("b2b_done", 64'(e_resp), 64'd0);
      chk("b2b_cnt",  64'(e_cnt),  sx(64'd2));
      chk("b2b_addr", 64'(e_addr), sx(64'h104));

      // OKAY-mode read
      do_reset();
      step(1'b1, T_NONSEQ, 32'h4000_0000, 1'b0, 1'b0);
      chk("okay_ready", 64'(o_ready), 64'd1);
      chk("okay_resp",  64'(o_resp),  64'd0);
      chk("okay_rdata", 64'(o_rdata), 64'd0);
      chk("okay_cnt",   64'(o_cnt),   sx(64'd1));
      chk("okay_addr",  64'(o_addr),  sx(64'h4000_0000));
      idle_step();
      idle_step();

      // saturation on the 4-bit counter, then clear coinciding with a transfer
      do_reset();
      for (int i = 0; i < 17; i++) begin
         step(1'b1, T_NONSEQ, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
         step(1'b1, T_NONSEQ, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      end
      chk("sat_cnt_e",  64'(e_cnt),  sx(64'd15));
      chk("sat_cnt_o",  64'(o_cnt),  sx(64'd17));
      chk("sat_addr",   64'(e_addr), sx(64'h1040));
      step(1'b1, T_NONSEQ, 32'h20, 1'b1, 1'b1);
      chk("clr_cnt_e",  64'(e_cnt),  sx(64'd1));
      chk("clr_cnt_o",  64'(o_cnt),  sx(64'd1));
      chk("clr_addr",   64'(e_addr), sx(64'h20));
      chk("clr_wr",     64'(e_wr),   sx(64'd1));
      idle_step();
      idle_step();
      step(1'b0, T_IDLE, 32'h0, 1'b0, 1'b1);
      chk("clr_only_cnt",  64'(e_cnt),  64'd0);
      chk("clr_only_addr", 64'(e_addr), 64'd0);
      idle_step();

      // reset asserted during ERR1
      step(1'b1, T_NONSEQ, 32'h300, 1'b1, 1'b0);
      chk("mid_err1", 64'(e_ready), 64'd0);
      hsel = 1'b0; htrans = T_IDLE;
      HRESETn = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(e_ready), 64'd1);
      chk("mid_rst_resp",  64'(e_resp),  64'd0);
      chk("mid_rst_cnt",   64'(e_cnt),   64'd0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      idle_step();
      chk("post_rst_ready", 64'(e_ready), 64'd1);
      chk("post_rst_resp",  64'(e_resp),  64'd0);
      idle_step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
